move_deserializer: RTL and testbench
====================================

MOVE_DESERIALIZER -- requirements
Module: move_deserializer

Interface
REQ-001 SHALL have parameter BEATS, default 2, meaning the number of 4-nibble beats per packed word; legal range 1..3.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, begins a new word collection (clears prior result).
REQ-005 SHALL have port valid, input, 1, in1..in4 carry a beat this cycle.
REQ-006 SHALL have ports in1, in2, in3, in4, input, 4 each, move nibbles of one beat; in1 is most significant.
REQ-007 SHALL have port ready, output, 1, block accepts a beat this cycle.
REQ-008 SHALL have port out, output, 16*BEATS, packed word; first beat's in1 occupies the top nibble.
REQ-009 SHALL have port move_count_out, output, 4, number of nonzero nibbles in out.
REQ-010 SHALL have port done, output, 1, out and move_count_out are complete and stable.

Function
REQ-011 SHALL implement states IDLE, COLLECT, DONE.
REQ-012 SHALL drive ready=1 only in COLLECT, combinationally from state.
- Transfer occurs when valid && ready at posedge clk.
REQ-013 SHALL, on a transfer, update the shift register as out_reg <= {out_reg[16*BEATS-17:0], in1, in2, in3, in4}.
- For BEATS=1 the transfer loads {in1,in2,in3,in4} directly.
REQ-014 SHALL, on a transfer, add to the move counter the count (0..4) of nonzero nibbles among in1..in4.
- Zero nibbles are empty moves: stored in out, not counted.
REQ-015 SHALL keep a beat counter, 2 bits, incremented per transfer.
REQ-016 SHALL perform the following transitions:
- IDLE->COLLECT on start.
- COLLECT->DONE on the transfer that makes beat count equal BEATS.
- DONE->COLLECT on start.
- Otherwise hold state.
REQ-017 SHALL, on start (any state), clear out_reg, move counter, and beat counter to 0, deassert done, and enter COLLECT next cycle.
REQ-018 SHALL give start priority over valid in the same cycle: the beat is discarded, not counted.
REQ-019 SHALL treat start during COLLECT as abort-and-restart per REQ-017; partial data is lost.
REQ-020 SHALL register done=1 in the cycle after the final transfer.
- Latency from final transfer edge to done high: 1 clock.
- out and move_count_out are valid on that same cycle.
REQ-021 SHALL hold done, out, and move_count_out constant in DONE until start; valid in DONE and IDLE is ignored.
REQ-022 SHALL drive out directly from out_reg.
REQ-023 SHALL update move_count_out only on entry to DONE; it otherwise holds its last value (0 after start).
REQ-024 SHALL never wrap the move counter; maximum 4*BEATS <= 12 fits 4 bits.

Reset
REQ-025 SHALL, on rst_n=0, immediately force the following regardless of clk:
- state=IDLE.
- out=0, move_count_out=0, done=0, ready=0.
- beat counter=0, move counter=0.
REQ-026 SHALL, when reset is asserted mid-COLLECT, discard the partial word; after rst_n rises, the block waits in IDLE for start.
REQ-027 SHALL take its first state change from the first posedge clk with rst_n=1.

Verification
REQ-028 SHALL cover the basic two-beat collection (BEATS=2):
- Stimulus: start; beat 1 = 1,2,3,4; beat 2 = 5,0,0,6.
- Required response: one cycle after the second transfer, done=1, out=32'h12345006, move_count_out=6.
REQ-029 SHALL cover valid gaps:
- Stimulus: start; beat A,B,C,D; valid low 3 cycles; beat E,F,1,2.
- Required response: out=32'hABCDEF12, move_count_out=8, and done not asserted during the gap.
REQ-030 SHALL cover start+valid collision:
- Stimulus: start with valid=1 carrying 9,9,9,9; then beats 0,0,0,1 and 0,0,2,0.
- Required response: out=32'h00010020, move_count_out=2.
REQ-031 SHALL cover abort, DONE hold, and restart:
- Stimulus: after one beat 7,7,7,7, assert start; then beats 0,0,0,0 twice.
- Required response: out=0, move_count_out=0, done=1.
- Then valid with 5,5,5,5 in DONE: no change.
REQ-032 SHALL cover asynchronous reset mid-operation:
- Stimulus: rst_n low between clock edges during COLLECT.
- Required response: out=0, done=0, ready=0 without a clock edge.
- After release with no start, ready stays 0.

Source files
------------

// File: rtl/move_deserializer.sv
// rtl/move_deserializer.sv - collects BEATS beats of four move nibbles into one packed word with a nonzero-move count
module move_deserializer #(
    parameter int BEATS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  valid,
    input  logic [3:0]            in1,
    input  logic [3:0]            in2,
    input  logic [3:0]            in3,
    input  logic [3:0]            in4,
    output logic                  ready,
    output logic [16*BEATS-1:0]   out,
    output logic [3:0]            move_count_out,
    output logic                  done
);

    localparam int W = 16 * BEATS;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [W-1:0] out_reg;
    logic [W-1:0] out_shift;
    logic [15:0]  beat;
    logic [2:0]   nz_count;
    logic [3:0]   move_cnt;
    logic [3:0]   move_cnt_next;
    logic [3:0]   move_count_reg;
    logic [1:0]   beat_cnt;
    logic         done_reg;
    logic         transfer;
    logic         last_transfer;

    assign beat     = {in1, in2, in3, in4};
    assign nz_count = {2'b00, |in1} + {2'b00, |in2} + {2'b00, |in3} + {2'b00, |in4};

    // start wins over valid, so a colliding beat never reaches the datapath
    assign transfer      = valid && (state == COLLECT) && !start;
    assign last_transfer = transfer && (beat_cnt == LAST_BEAT);
    assign move_cnt_next = move_cnt + {1'b0, nz_count};

    generate
        if (BEATS == 1) begin : g_single
            assign out_shift = beat;
        end else begin : g_multi
            assign out_shift = {out_reg[W-17:0], beat};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                ready = 1'b1;
                if (start) begin
                    next_state = COLLECT;
                end else if (last_transfer) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = COLLECT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            move_cnt       <= '0;
            beat_cnt       <= '0;
            move_count_reg <= '0;
            done_reg       <= 1'b0;
        end else if (start) begin
            out_reg        <= '0;
            move_cnt       <= '0;
            beat_cnt       <= '0;
            move_count_reg <= '0;
            done_reg       <= 1'b0;
        end else if (transfer) begin
            out_reg  <= out_shift;
            move_cnt <= move_cnt_next;
            beat_cnt <= beat_cnt + 2'd1;
            if (last_transfer) begin
                done_reg       <= 1'b1;
                move_count_reg <= move_cnt_next;
            end
        end
    end

    assign out            = out_reg;
    assign move_count_out = move_count_reg;
    assign done           = done_reg;

endmodule

// File: tb/tb_move_deserializer.sv
// tb/tb_move_deserializer.sv - randomized self-checking bench for move_deserializer
module tb_move_deserializer;

    localparam int BEATS = 2;
    localparam int W     = 16 * BEATS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         valid;
    logic [3:0]   in1, in2, in3, in4;
    logic         ready;
    logic [W-1:0] out;
    logic [3:0]   move_count_out;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_word;
    int           model_cnt;

    move_deserializer #(.BEATS(BEATS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .valid         (valid),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .in4           (in4),
        .ready         (ready),
        .out           (out),
        .move_count_out(move_count_out),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        model_word = '0;
        model_cnt  = 0;
    endtask

    task automatic model_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        model_word = (model_word << 16) | W'({a, b, c, d});
        model_cnt  = model_cnt + (a != 0) + (b != 0) + (c != 0) + (d != 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start();
    endtask

    task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        valid = 1'b1;
        {in1, in2, in3, in4} = {a, b, c, d};
        tick();
        valid = 1'b0;
        model_beat(a, b, c, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        {in1, in2, in3, in4} = 16'h0;
        #12;
        checks++;
        if ({ready, done, move_count_out, out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b done=%0b cnt=%0d out=%h, want all zero", ready, done, move_count_out, out);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready: got %0b want 0", ready);
        end
    endtask

    task automatic test_basic();
        do_start();
        checks++;
        if (ready !== 1'b1 || move_count_out !== 4'd0) begin
            errors++;
            $display("FAIL basic_collect_entry: got ready=%0b cnt=%0d want ready=1 cnt=0", ready, move_count_out);
        end
        send_beat(4'h1, 4'h2, 4'h3, 4'h4);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_mid_done: got %0b want 0", done);
        end
        send_beat(4'h5, 4'h0, 4'h0, 4'h6);
        checks++;
        if (done !== 1'b1 || out !== 32'h12345006 || move_count_out !== 4'd6 || ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_word: got done=%0b out=%h cnt=%0d ready=%0b want 1 12345006 6 0", done, out, move_count_out, ready);
        end
    endtask

    task automatic test_gaps();
        do_start();
        send_beat(4'hA, 4'hB, 4'hC, 4'hD);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_cycle%0d: got done=%0b ready=%0b want 0 1", i, done, ready);
            end
        end
        send_beat(4'hE, 4'hF, 4'h1, 4'h2);
        checks++;
        if (done !== 1'b1 || out !== 32'hABCDEF12 || move_count_out !== 4'd8) begin
            errors++;
            $display("FAIL gap_word: got done=%0b out=%h cnt=%0d want 1 abcdef12 8", done, out, move_count_out);
        end
    endtask

    task automatic test_collision();
        start = 1'b1;
        valid = 1'b1;
        {in1, in2, in3, in4} = 16'h9999;
        tick();
        start = 1'b0;
        valid = 1'b0;
        checks++;
        if (out !== '0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_discard: got out=%h ready=%0b want 0 1", out, ready);
        end
        send_beat(4'h0, 4'h0, 4'h0, 4'h1);
        send_beat(4'h0, 4'h0, 4'h2, 4'h0);
        checks++;
        if (done !== 1'b1 || out !== 32'h00010020 || move_count_out !== 4'd2) begin
            errors++;
            $display("FAIL collision_word: got done=%0b out=%h cnt=%0d want 1 00010020 2", done, out, move_count_out);
        end
    endtask

    task automatic test_abort_hold();
        do_start();
        checks++;
        if (move_count_out !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: got cnt=%0d done=%0b want 0 0", move_count_out, done);
        end
        send_beat(4'h7, 4'h7, 4'h7, 4'h7);
        do_start();
        send_beat(4'h0, 4'h0, 4'h0, 4'h0);
        send_beat(4'h0, 4'h0, 4'h0, 4'h0);
        checks++;
        if (done !== 1'b1 || out !== '0 || move_count_out !== 4'd0) begin
            errors++;
            $display("FAIL abort_word: got done=%0b out=%h cnt=%0d want 1 0 0", done, out, move_count_out);
        end
        valid = 1'b1;
        {in1, in2, in3, in4} = 16'h5555;
        repeat (2) tick();
        valid = 1'b0;
        checks++;
        if (done !== 1'b1 || out !== '0 || move_count_out !== 4'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got done=%0b out=%h cnt=%0d ready=%0b want 1 0 0 0", done, out, move_count_out, ready);
        end
    endtask

    task automatic test_async_reset();
        do_start();
        send_beat(4'h3, 4'h1, 4'h4, 4'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || done !== 1'b0 || ready !== 1'b0 || move_count_out !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: got out=%h done=%0b ready=%0b cnt=%0d want 0 0 0 0", out, done, ready, move_count_out);
        end
        #1;
        rst_n = 1'b1;
        valid = 1'b1;
        {in1, in2, in3, in4} = 16'h1111;
        repeat (3) tick();
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0 || out !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got ready=%0b out=%h done=%0b want 0 0 0", ready, out, done);
        end
    endtask

    function automatic logic [3:0] rand_nibble();
        return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endfunction

    task automatic test_random();
        for (int w = 0; w < 40; w++) begin
            do_start();
            if ($urandom_range(0, 4) == 0) begin
                send_beat(rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble());
                do_start();
            end
            for (int b = 0; b < BEATS; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_early_done w%0d b%0d: got %0b want 0", w, b, done);
                end
                send_beat(rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble());
            end
            if ($urandom_range(0, 1) == 1) begin
                valid = 1'b1;
                {in1, in2, in3, in4} = 16'($urandom());
                tick();
                valid = 1'b0;
            end
            checks++;
            if (done !== 1'b1 || out !== model_word || move_count_out !== 4'(model_cnt)) begin
                errors++;
                $display("FAIL rand_word w%0d: got done=%0b out=%h cnt=%0d want 1 %h %0d", w, done, out, move_count_out, model_word, model_cnt);
            end
        end
    endtask

    initial begin
        model_start();
        test_reset();
        test_basic();
        test_gaps();
        test_collision();
        test_abort_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
